rom_fetch: RTL and testbench

Instruction prefetch unit: the reading end of the program ROM. It drives the ROM address with a sequential fetch PC and captures the 32-bit words the ROM returns. Captured words are buffered in a small FIFO and handed to the CPU decode stage over a valid/ready interface. A jump request redirects fetching and flushes everything in flight.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/rom_fetch.sv | 102 ++++++++++
 tb/tb_rom_fetch.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, reset address and FSM encoding for the prefetch unit
package fetch_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] DEF_RESET_ADDR = 16'h0000;

  typedef enum logic {
    ST_HALT  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO holding {fetch address, ROM word} pairs
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  fetch_entry_t                 push_data_i,
  input  logic                         pop_i,
  output fetch_entry_t                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Flush wins over both ends so a redirect discards the same-cycle push and pop.
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && (count_q != '0) && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(do_push && !do_pop && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/rom_fetch.sv
// rtl/rom_fetch.sv - sequential instruction prefetch from program ROM with jump redirect
module rom_fetch
  import fetch_pkg::*;
#(
  parameter int                DEPTH       = 4,
  parameter int                ROM_LATENCY = 1,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = DEF_RESET_ADDR
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_addr
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inf_addr_q, inf_addr_d;
  logic              inflight_q, inflight_d;
  logic              issue;
  logic              push;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;
  logic [CNT_W-1:0]  count;

  // Credit ignores a same-cycle pop so instr_ready never reaches the PC.
  assign issue = (state_q == ST_FETCH) && !jump_valid &&
                 ((int'(count) + int'(inflight_q)) < DEPTH);
  assign pop   = instr_valid && instr_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = 1'b0;
    inf_addr_d = inf_addr_q;
    push       = 1'b0;
    push_entry = '0;

    case (state_q)
      ST_HALT:  if (run)  state_d = ST_FETCH;
      ST_FETCH: if (!run) state_d = ST_HALT;
      default:  state_d = ST_HALT;
    endcase

    if (jump_valid) pc_d = jump_addr;
    else if (issue) pc_d = pc_q + 1'b1;

    if (issue) inf_addr_d = pc_q;

    if (ROM_LATENCY == 0) begin
      push            = issue;
      push_entry.addr = pc_q;
    end else begin
      inflight_d      = issue;
      push            = inflight_q;
      push_entry.addr = inf_addr_q;
    end
    push_entry.data = rom_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_HALT;
      pc_q       <= RESET_ADDR;
      inflight_q <= 1'b0;
      inf_addr_q <= RESET_ADDR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      inf_addr_q <= inf_addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_i      (RST),
    .flush_i    (jump_valid),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count)
  );

  assign rom_addr    = pc_q;
  assign instr_valid = (count != '0);
  assign instr_data  = head.data;
  assign instr_addr  = head.addr;

endmodule

// File: tb/tb_rom_fetch.sv
// tb/tb_rom_fetch.sv - checks rom_fetch at ROM latency 0 and 1 against a queue model
module tb_rom_fetch;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        run;
  logic        jump_valid;
  logic [15:0] jump_addr;
  logic        instr_ready;

  logic [15:0] rom_addr0, rom_addr1, instr_addr0, instr_addr1;
  logic [31:0] rom_data0, rom_data1, instr_data0, instr_data1;
  logic        instr_valid0, instr_valid1;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rom_fn(input logic [15:0] a);
    case (a)
      16'h0000: rom_fn = 32'h00010006;
      16'h0001: rom_fn = 32'h00002006;
      16'h0002: rom_fn = 32'h00004006;
      16'h0007: rom_fn = 32'h00086042;
      16'h0008: rom_fn = 32'h00030188;
      default:  rom_fn = {~a, a};
    endcase
  endfunction

  assign rom_data0 = rom_fn(rom_addr0);
  always @(posedge CLK) rom_data1 <= rom_fn(rom_addr1);

  rom_fetch #(.DEPTH(DEPTH), .ROM_LATENCY(0), .RESET_ADDR(16'h0000)) u_dut0 (
    .CLK(CLK), .RST(RST), .run(run), .rom_addr(rom_addr0), .rom_data(rom_data0),
    .jump_valid(jump_valid), .jump_addr(jump_addr), .instr_valid(instr_valid0),
    .instr_ready(instr_ready), .instr_data(instr_data0), .instr_addr(instr_addr0));

  rom_fetch #(.DEPTH(DEPTH), .ROM_LATENCY(1), .RESET_ADDR(16'h0000)) u_dut1 (
    .CLK(CLK), .RST(RST), .run(run), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .jump_valid(jump_valid), .jump_addr(jump_addr), .instr_valid(instr_valid1),
    .instr_ready(instr_ready), .instr_data(instr_data1), .instr_addr(instr_addr1));

  logic [15:0] o_rom   [2];
  logic        o_valid [2];
  logic [15:0] o_iaddr [2];
  logic [31:0] o_idata [2];
  assign o_rom[0] = rom_addr0;      assign o_rom[1] = rom_addr1;
  assign o_valid[0] = instr_valid0; assign o_valid[1] = instr_valid1;
  assign o_iaddr[0] = instr_addr0;  assign o_iaddr[1] = instr_addr1;
  assign o_idata[0] = instr_data0;  assign o_idata[1] = instr_data1;

  // Model: index k is the ROM latency of the instance it predicts.
  logic [15:0] mpc   [2];
  bit          mfetch[2];
  bit          minf  [2];
  logic [15:0] minfa [2];
  int          mcnt  [2];
  logic [47:0] mbuf  [2][16];

  bit          last_valid[2];
  logic [15:0] last_addr [2];
  logic [31:0] last_data [2];
  logic [15:0] log_addr [2][256];
  logic [31:0] log_data [2][256];
  int          log_cyc  [2][256];
  int          log_n    [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input int k, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[lat%0d]: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  task automatic chk_log(input string name, input int k, input int idx,
                         input logic [15:0] exp_addr, input logic [31:0] exp_data, input bit with_data);
    n_checks++;
    if (idx >= log_n[k]) begin
      n_errors++;
      $display("FAIL %s[lat%0d]: word %0d not delivered, expected addr %0h", name, k, idx, exp_addr);
    end else if (log_addr[k][idx] !== exp_addr || (with_data && log_data[k][idx] !== exp_data)) begin
      n_errors++;
      $display("FAIL %s[lat%0d]: got (%0h,%0h) expected (%0h,%0h)", name, k,
               log_addr[k][idx], log_data[k][idx], exp_addr, exp_data);
    end
  endtask

  task automatic chk_gap(input string name, input int k, input int idx);
    int d;
    d = (idx + 1 < log_n[k]) ? (log_cyc[k][idx+1] - log_cyc[k][idx]) : -1;
    chk(name, k, 48'(d), 48'd1);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mpc[k] = 16'h0000; mfetch[k] = 1'b0; minf[k] = 1'b0; minfa[k] = 16'h0000;
      mcnt[k] = 0; last_valid[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit iss, pop, psh;
      logic [47:0] item;
      if (last_valid[k] && instr_ready && !jump_valid && log_n[k] < 256) begin
        log_addr[k][log_n[k]] = last_addr[k];
        log_data[k][log_n[k]] = last_data[k];
        log_cyc[k][log_n[k]]  = cyc;
        log_n[k]++;
      end
      pop = (mcnt[k] > 0) && instr_ready;
      if (jump_valid) begin
        mcnt[k] = 0; minf[k] = 1'b0; mpc[k] = jump_addr;
      end else begin
        iss  = mfetch[k] && (mcnt[k] + int'(minf[k]) < DEPTH);
        psh  = 1'b0;
        item = '0;
        if (k == 0) begin
          if (iss) begin psh = 1'b1; item = {mpc[k], rom_fn(mpc[k])}; end
        end else begin
          if (minf[k]) begin psh = 1'b1; item = {minfa[k], rom_fn(minfa[k])}; end
          minf[k] = iss;
          if (iss) minfa[k] = mpc[k];
        end
        if (pop) begin
          for (int i = 0; i < 15; i++) mbuf[k][i] = mbuf[k][i+1];
          mcnt[k]--;
        end
        if (psh) begin mbuf[k][mcnt[k]] = item; mcnt[k]++; end
        if (iss) mpc[k] = mpc[k] + 16'd1;
      end
      mfetch[k] = run;
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      chk("rom_addr", k, 48'(o_rom[k]), 48'(mpc[k]));
      chk("instr_valid", k, 48'(o_valid[k]), 48'(mcnt[k] > 0));
      if (mcnt[k] > 0) begin
        chk("instr_addr", k, 48'(o_iaddr[k]), 48'(mbuf[k][0][47:32]));
        chk("instr_data", k, 48'(o_idata[k]), 48'(mbuf[k][0][31:0]));
      end
      last_valid[k] = o_valid[k];
      last_addr[k]  = o_iaddr[k];
      last_data[k]  = o_idata[k];
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST) model_reset();
    else model_step();
    cyc++;
    @(negedge CLK);
    compare();
  endtask

  task automatic measure_first_valid(input string name);
    int fv [2];
    fv[0] = 0; fv[1] = 0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      for (int k = 0; k < 2; k++) if (fv[k] == 0 && o_valid[k]) fv[k] = n;
    end
    chk(name, 0, 48'(fv[0]), 48'd2);
    chk(name, 1, 48'(fv[1]), 48'd3);
  endtask

  task automatic do_jump(input logic [15:0] a);
    jump_valid = 1'b1; jump_addr = a;
    tick();
    jump_valid = 1'b0;
  endtask

  int lb [2];

  initial begin
    RST = 1'b1; run = 1'b0; jump_valid = 1'b0; jump_addr = 16'h0000; instr_ready = 1'b0;
    log_n[0] = 0; log_n[1] = 0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_valid", k, 48'(o_valid[k]), 48'd0);
      chk("reset_rom_addr", k, 48'(o_rom[k]), 48'h0000);
      chk("reset_instr_data", k, 48'(o_idata[k]), 48'h0);
      chk("reset_instr_addr", k, 48'(o_iaddr[k]), 48'h0);
    end
    tick(); tick();
    RST = 1'b0;
    tick();

    // Start-up stream from address 0
    run = 1'b1; instr_ready = 1'b1;
    lb[0] = log_n[0]; lb[1] = log_n[1];
    measure_first_valid("first_valid");
    for (int k = 0; k < 2; k++) begin
      chk_log("startup_w0", k, lb[k] + 0, 16'h0000, 32'h00010006, 1'b1);
      chk_log("startup_w1", k, lb[k] + 1, 16'h0001, 32'h00002006, 1'b1);
      chk_log("startup_w2", k, lb[k] + 2, 16'h0002, 32'h00004006, 1'b1);
      chk_gap("startup_gap0", k, lb[k] + 0);
      chk_gap("startup_gap1", k, lb[k] + 1);
    end

    // Backpressure: FIFO fills, PC parks at 4
    instr_ready = 1'b0;
    do_jump(16'h0000);
    repeat (10) tick();
    for (int k = 0; k < 2; k++) begin
      chk("stall_rom_addr", k, 48'(o_rom[k]), 48'h0004);
      chk("stall_head_addr", k, 48'(o_iaddr[k]), 48'h0000);
    end
    lb[0] = log_n[0]; lb[1] = log_n[1];
    instr_ready = 1'b1;
    repeat (10) tick();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 6; i++) begin
        chk_log("drain_order", k, lb[k] + i, 16'(i), 32'h0, 1'b0);
        if (i < 5) chk_gap("drain_gap", k, lb[k] + i);
      end

    // Jump flushes buffered and in-flight words
    instr_ready = 1'b0;
    do_jump(16'h0020);
    repeat (4) tick();
    for (int k = 0; k < 2; k++) chk("prejump_rom_addr", k, 48'(o_rom[k]), 48'h0024);
    instr_ready = 1'b1;
    do_jump(16'h0007);
    for (int k = 0; k < 2; k++) chk("jump_valid_drop", k, 48'(o_valid[k]), 48'd0);
    lb[0] = log_n[0]; lb[1] = log_n[1];
    repeat (6) tick();
    for (int k = 0; k < 2; k++) begin
      chk_log("jump_w0", k, lb[k] + 0, 16'h0007, 32'h00086042, 1'b1);
      chk_log("jump_w1", k, lb[k] + 1, 16'h0008, 32'h00030188, 1'b1);
    end

    // Address wrap
    do_jump(16'hFFFE);
    lb[0] = log_n[0]; lb[1] = log_n[1];
    repeat (6) tick();
    for (int k = 0; k < 2; k++) begin
      chk_log("wrap_w0", k, lb[k] + 0, 16'hFFFE, 32'h0001FFFE, 1'b1);
      chk_log("wrap_w1", k, lb[k] + 1, 16'hFFFF, 32'h0000FFFF, 1'b1);
      chk_log("wrap_w2", k, lb[k] + 2, 16'h0000, 32'h00010006, 1'b1);
    end

    // run dropped mid-stream
    do_jump(16'h0040);
    repeat (3) tick();
    run = 1'b0;
    repeat (8) tick();
    for (int k = 0; k < 2; k++) begin
      chk("halt_rom_addr", k, 48'(o_rom[k]), 48'h0044);
      chk("halt_valid", k, 48'(o_valid[k]), 48'd0);
      chk_log("halt_last_word", k, log_n[k] - 1, 16'h0043, 32'h0, 1'b0);
    end
    lb[0] = log_n[0]; lb[1] = log_n[1];
    run = 1'b1;
    repeat (6) tick();
    for (int k = 0; k < 2; k++) chk_log("resume_word", k, lb[k], 16'h0044, 32'h0, 1'b0);

    // Asynchronous reset mid-burst
    #2 RST = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("async_rst_valid", k, 48'(o_valid[k]), 48'd0);
      chk("async_rst_rom_addr", k, 48'(o_rom[k]), 48'h0000);
      chk("async_rst_instr_data", k, 48'(o_idata[k]), 48'h0);
    end
    model_reset();
    tick();
    RST = 1'b0;
    lb[0] = log_n[0]; lb[1] = log_n[1];
    measure_first_valid("first_valid_after_rst");
    for (int k = 0; k < 2; k++) chk_log("after_rst_w0", k, lb[k], 16'h0000, 32'h00010006, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
